// File: rtl/setscore_ctrl.sv
// Set-score menu controller: conditions the up/down/ok buttons, runs the menu FSM,
// holds the target score and pulses start once the player confirms it.
module setscore_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCORE_MIN       = 1,
  parameter int SCORE_MAX       = 21,
  parameter int SCORE_DEFAULT   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_menu,
  input  logic       btn_up_raw,
  input  logic       btn_dn_raw,
  input  logic       btn_ok_raw,
  output logic [4:0] score,
  output logic       menu_active,
  output logic       start
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       S_MIN    = 5'(SCORE_MIN);
  localparam logic [4:0]       S_MAX    = 5'(SCORE_MAX);
  localparam logic [4:0]       S_DEF    = 5'(SCORE_DEFAULT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EDIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [2:0]       btn_raw;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       db;
  logic [2:0]       db_q;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt [3];
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [4:0]       score_nxt;
  logic             btn_up;
  logic             btn_dn;
  logic             btn_ok;

  // Bit order for the conditioned vectors: [0]=up, [1]=down, [2]=ok.
  assign btn_raw = {btn_ok_raw, btn_dn_raw, btn_up_raw};
  assign press   = db & ~db_q;
  assign btn_up  = press[0];
  assign btn_dn  = press[1];
  assign btn_ok  = press[2];

  // The debounced level only follows the synchronised input after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      db_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      db_q   <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    score_nxt = score;
    case (state)
      IDLE: begin
        if (enter_menu) begin
          state_nxt = EDIT;
        end
      end
      EDIT: begin
        if (btn_ok) begin
          state_nxt = DONE;
        end else if (btn_up && !btn_dn) begin
          if (score < S_MAX) begin
            score_nxt = score + 5'd1;
          end
        end else if (btn_dn && !btn_up) begin
          if (score > S_MIN) begin
            score_nxt = score - 5'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      score       <= S_DEF;
      menu_active <= 1'b0;
      start       <= 1'b0;
    end else begin
      state       <= state_nxt;
      score       <= score_nxt;
      menu_active <= (state_nxt == EDIT);
      start       <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_setscore_ctrl.sv
// Bench for setscore_ctrl: directed vector table, hand-written press sequences,
// then random button activity compared against a sliding-window reference model.
module tb_setscore_ctrl;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       enter_menu;
  logic       btn_up_raw;
  logic       btn_dn_raw;
  logic       btn_ok_raw;
  logic [4:0] score;
  logic       menu_active;
  logic       start;

  int checks = 0;
  int errors = 0;

  setscore_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SCORE_MIN(1),
    .SCORE_MAX(21),
    .SCORE_DEFAULT(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enter_menu(enter_menu),
    .btn_up_raw(btn_up_raw),
    .btn_dn_raw(btn_dn_raw),
    .btn_ok_raw(btn_ok_raw),
    .score(score),
    .menu_active(menu_active),
    .start(start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronised samples all agree;
  // a press is a rise of that level and acts one edge later.
  bit [D+1:0] m_hist [3];
  bit [2:0]   m_db;
  bit [2:0]   m_db_prev;
  int         m_score;
  bit         m_menu;
  bit         m_done;

  always @(posedge clk) begin
    bit [2:0] p;
    bit [2:0] raw;
    bit [D-1:0] win;
    if (reset) begin
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      m_db      = '0;
      m_db_prev = '0;
      m_score   = 5;
      m_menu    = 1'b0;
      m_done    = 1'b0;
    end else begin
      p = m_db & ~m_db_prev;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_menu) begin
        if (enter_menu) m_menu = 1'b1;
      end else if (p[2]) begin
        m_menu = 1'b0;
        m_done = 1'b1;
      end else if (p[0] && !p[1]) begin
        m_score = (m_score < 21) ? m_score + 1 : 21;
      end else if (p[1] && !p[0]) begin
        m_score = (m_score > 1) ? m_score - 1 : 1;
      end
      m_db_prev = m_db;
      raw = {btn_ok_raw, btn_dn_raw, btn_up_raw};
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][D:0], raw[b]};
        win = m_hist[b][D+1:2];
        if (&win) m_db[b] = 1'b1;
        else if (~|win) m_db[b] = 1'b0;
      end
    end
  end

  typedef struct {
    bit    en;
    bit    up;
    bit    dn;
    bit    ok;
    int    cycles;
    int    exp_score;
    bit    exp_menu;
    bit    exp_start;
    string name;
  } vec_t;

  vec_t tab [$];

  task automatic checkOutput(input string name, input int es, input bit em, input bit est);
    checks++;
    if (int'(score) != es || menu_active !== em || start !== est) begin
      errors++;
      $display("[TB] FAIL %s: got score=%0d menu_active=%0b start=%0b, expected score=%0d menu_active=%0b start=%0b",
               name, score, menu_active, start, es, em, est);
    end
  endtask

  // Inputs change #1 after a rising edge; enter_menu is held for the first cycle only.
  task automatic applyStimulus(input bit en, input bit up, input bit dn, input bit ok, input int n);
    enter_menu = en;
    btn_up_raw = up;
    btn_dn_raw = dn;
    btn_ok_raw = ok;
    repeat (n) begin
      @(posedge clk);
      #1;
      enter_menu = 1'b0;
    end
  endtask

  task automatic pressButton(input bit up, input bit dn);
    applyStimulus(1'b0, up, dn, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6);
  endtask

  task automatic runTable(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(tab[i].en, tab[i].up, tab[i].dn, tab[i].ok, tab[i].cycles);
      checkOutput(tab[i].name, tab[i].exp_score, tab[i].exp_menu, tab[i].exp_start);
    end
  endtask

  initial begin
    int exp_score;

    tab.push_back('{1, 0, 0, 0, 1, 5, 1, 0, "enter_menu"});
    tab.push_back('{0, 1, 0, 0, 6, 5, 1, 0, "up_edge5"});
    tab.push_back('{0, 1, 0, 0, 1, 6, 1, 0, "up_edge6"});
    tab.push_back('{0, 1, 0, 0, 3, 6, 1, 0, "up_hold10"});
    tab.push_back('{0, 0, 0, 0, 8, 6, 1, 0, "up_release"});
    tab.push_back('{0, 1, 0, 0, 3, 6, 1, 0, "up_glitch"});
    tab.push_back('{0, 0, 0, 0, 8, 6, 1, 0, "glitch_settle"});
    tab.push_back('{0, 1, 1, 0, 7, 1, 1, 0, "updn_aligned"});
    tab.push_back('{0, 0, 0, 0, 8, 1, 1, 0, "updn_release"});
    tab.push_back('{0, 1, 0, 1, 6, 1, 1, 0, "okup_edge5"});
    tab.push_back('{0, 1, 0, 1, 1, 1, 0, 1, "okup_start"});
    tab.push_back('{0, 1, 0, 1, 1, 1, 0, 0, "okup_after"});
    tab.push_back('{0, 0, 0, 0, 8, 1, 0, 0, "ok_release"});
    tab.push_back('{0, 1, 0, 0, 8, 1, 0, 0, "idle_up"});
    tab.push_back('{0, 0, 0, 0, 8, 1, 0, 0, "idle_up_rel"});
    tab.push_back('{0, 0, 0, 1, 8, 1, 0, 0, "idle_ok"});
    tab.push_back('{0, 0, 0, 0, 8, 1, 0, 0, "idle_ok_rel"});
    tab.push_back('{0, 0, 1, 0, 8, 1, 0, 0, "idle_dn"});
    tab.push_back('{0, 0, 0, 0, 8, 1, 0, 0, "idle_dn_rel"});
    tab.push_back('{1, 0, 0, 0, 1, 1, 1, 0, "reenter"});

    reset      = 1'b1;
    enter_menu = 1'b0;
    btn_up_raw = 1'b0;
    btn_dn_raw = 1'b0;
    btn_ok_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_state", 5, 1'b0, 1'b0);

    runTable(0, 6);

    exp_score = 6;
    for (int i = 0; i < 20; i++) begin
      pressButton(1'b1, 1'b0);
      exp_score = (exp_score < 21) ? exp_score + 1 : 21;
      checkOutput($sformatf("up_press%0d", i), exp_score, 1'b1, 1'b0);
    end
    for (int i = 0; i < 25; i++) begin
      pressButton(1'b0, 1'b1);
      exp_score = (exp_score > 1) ? exp_score - 1 : 1;
      checkOutput($sformatf("dn_press%0d", i), exp_score, 1'b1, 1'b0);
    end

    runTable(7, tab.size() - 1);

    for (int i = 0; i < 11; i++) pressButton(1'b1, 1'b0);
    checkOutput("set_12", 12, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_mid_edit", 5, 1'b0, 1'b0);
    pressButton(1'b1, 1'b0);
    checkOutput("idle_after_reset", 5, 1'b0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 399) == 0);
      enter_menu = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) btn_up_raw = ~btn_up_raw;
      if ($urandom_range(0, 4) == 0) btn_dn_raw = ~btn_dn_raw;
      if ($urandom_range(0, 5) == 0) btn_ok_raw = ~btn_ok_raw;
      @(posedge clk);
      #1;
      checkOutput($sformatf("random%0d", c), m_score, m_menu, m_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
